lbp_scan_ctrl: RTL and testbench
================================

LBP_SCAN_CTRL -- requirements
Module: lbp_scan_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 128, meaning image width and height in pixels.
REQ-002 The block SHALL have parameter ADDR_W, default 14, meaning pixel address width (log2 of IMG_W*IMG_W).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port gray_ready, input, 1 bit: gray image memory available.
REQ-006 Port gray_req, output, 1 bit: read strobe to gray memory; data returns in the same cycle.
REQ-007 Port gray_addr, output, ADDR_W bits: gray memory read address.
REQ-008 Port win_we, output, 1 bit: datapath captures gray_data into window slot win_idx at cycle end.
REQ-009 Port win_idx, output, 4 bits: window slot, idx = 3*dr + dc, where dr and dc are 0..2 relative to (r-1, c-1); centre is idx 4.
REQ-010 Port win_shift, output, 1 bit: datapath shifts window one column left at cycle end.
REQ-011 Port lbp_valid, output, 1 bit: write strobe; the datapath's combinational lbp_data is written this cycle.
REQ-012 Port lbp_addr, output, ADDR_W bits: LBP result address, equal to r*IMG_W + c.
REQ-013 Port finish, output, 1 bit: whole image processed.

Function
REQ-014 Scan order SHALL be interior pixels only: rows r=1..IMG_W-2 outer, columns c=1..IMG_W-2 inner; border pixels are never written.
REQ-015 FSM states SHALL be IDLE, FETCH9, FETCH3, CALC, DONE.
REQ-016 IDLE SHALL go to FETCH9 with r=1, c=1 on the first cycle gray_ready=1; the first gray_req is asserted the following cycle.
REQ-017 FETCH9 SHALL issue 9 reads, slots 0..8 in order, gray_addr=(r-1+dr)*IMG_W+(c-1+dc), with gray_req=win_we=1 each cycle, then go to CALC.
REQ-018 FETCH3 SHALL issue 3 reads, slots 2,5,8, at column c+1 of rows r-1, r, r+1, then go to CALC.
REQ-019 CALC SHALL last exactly 1 cycle with lbp_valid=1, lbp_addr=r*IMG_W+c, gray_req=0.
REQ-020 On CALC exit with c<IMG_W-2: win_shift=1 in that CALC cycle, c increments, next state FETCH3.
REQ-021 On CALC exit with c=IMG_W-2 and r<IMG_W-2: win_shift=0, c=1, r increments, next state FETCH9.
REQ-022 On CALC exit with c=r=IMG_W-2: next state DONE.
REQ-023 DONE SHALL hold finish=1 with all strobes 0 until reset.
REQ-024 If gray_ready=0 during FETCH9 or FETCH3, the FSM SHALL stall: gray_req=win_we=0, read counter and address held; it resumes at the same slot when gray_ready=1.
REQ-025 CALC SHALL NOT be stalled by gray_ready.
REQ-026 gray_addr, win_idx and lbp_addr SHALL be don't-care when their strobe is 0, but SHALL be driven (never X after reset).
REQ-027 Throughput SHALL be 10 cycles per row-start pixel and 4 cycles per other pixel; IMG_W=128 gives 126*510 = 64260 cycles from first gray_req to last lbp_valid, with no stalls.
REQ-028 Counters SHALL be unsigned; address arithmetic SHALL be ADDR_W bits with no overflow for all legal r, c.

Reset
REQ-029 reset=1 SHALL force state IDLE, r=c=1, read counter 0, and all outputs 0 (gray_addr=0, lbp_addr=0, finish=0) at the next rising edge, from any state including mid-fetch and DONE.
REQ-030 reset SHALL take priority over gray_ready and all transitions.

Structure
REQ-031 Package lbp_pkg SHALL hold IMG_W, ADDR_W, the state enum and the window-slot constants (slot count 9, centre 4); the LBP datapath shares it.
REQ-032 One sub-module, lbp_addr_gen, SHALL be used: combinational mapping of (r, c, slot) to gray_addr and (r, c) to lbp_addr; the FSM and counters stay in lbp_scan_ctrl.

Verification
REQ-033 Reset check: hold reset for 2 cycles -> all outputs 0, state IDLE; gray_ready=1 then gives gray_req one cycle later.
REQ-034 First window: gray_addr sequence 0,1,2,128,129,130,256,257,258 with win_idx 0..8 -> then lbp_valid=1, lbp_addr=129, win_shift=1.
REQ-035 Slide and row wrap: next reads 3,131,259 on slots 2,5,8 -> lbp_addr=130; after lbp_addr=254 (win_shift=0), reads restart at 128 slot 0 -> lbp_addr=257.
REQ-036 Stall: drop gray_ready for 5 cycles at FETCH9 slot 4 -> gray_req=0 and gray_addr held at 129; after resume, slot 4 is reissued and the sequence completes unchanged.
REQ-037 Full frame with a random-pattern golden model: 15876 lbp_valid pulses, last lbp_addr=16254 at cycle 64260, finish=1 the next cycle and held; no write to any border address.
REQ-038 Reset mid-frame at lbp_addr=5000, then restart -> complete frame matches golden and finish timing matches REQ-037.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP scan controller and its datapath:
// image geometry, scan FSM states and 3x3 window slot helpers.
package lbp_pkg;

   localparam int unsigned IMG_W       = 128;
   localparam int unsigned ADDR_W      = 14;
   localparam int unsigned SLOT_CNT    = 9;
   localparam int unsigned SLOT_CENTRE = 4;

   typedef enum logic [2:0] {
      IDLE,
      FETCH9,
      FETCH3,
      CALC,
      DONE
   } state_e;

   // Window slot idx = 3*dr + dc.
   function automatic logic [1:0] slot_row(input logic [3:0] slot);
      if (slot >= 4'd6)      return 2'd2;
      else if (slot >= 4'd3) return 2'd1;
      else                   return 2'd0;
   endfunction

   function automatic logic [1:0] slot_col(input logic [3:0] slot);
      return 2'(slot - 4'd3 * {2'b00, slot_row(slot)});
   endfunction

endpackage

// File: rtl/lbp_addr_gen.sv
// Combinational address mapping: (r, c, slot) to gray-memory address and
// (r, c) to LBP result address.
module lbp_addr_gen #(
   parameter int unsigned IMG_W  = lbp_pkg::IMG_W,
   parameter int unsigned ADDR_W = lbp_pkg::ADDR_W,
   parameter int unsigned RC_W   = $clog2(lbp_pkg::IMG_W)
) (
   input  logic [RC_W-1:0]   r_i,
   input  logic [RC_W-1:0]   c_i,
   input  logic [3:0]        slot_i,
   output logic [ADDR_W-1:0] gray_addr_o,
   output logic [ADDR_W-1:0] lbp_addr_o
);
   import lbp_pkg::*;

   logic [1:0] dr;
   logic [1:0] dc;

   // r and c are always >= 1, so the -1 offsets never wrap.
   always_comb begin
      dr          = slot_row(slot_i);
      dc          = slot_col(slot_i);
      gray_addr_o = (ADDR_W'(r_i) + ADDR_W'(dr) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                    + ADDR_W'(c_i) + ADDR_W'(dc) - ADDR_W'(1);
      lbp_addr_o  = ADDR_W'(r_i) * ADDR_W'(IMG_W) + ADDR_W'(c_i);
   end

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Scan controller for 3x3 LBP: walks interior pixels row by row, fetching a
// full window at row start and one new column per step afterwards.
module lbp_scan_ctrl #(
   parameter int unsigned IMG_W  = lbp_pkg::IMG_W,
   parameter int unsigned ADDR_W = lbp_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gray_ready,
   output logic              gray_req,
   output logic [ADDR_W-1:0] gray_addr,
   output logic              win_we,
   output logic [3:0]        win_idx,
   output logic              win_shift,
   output logic              lbp_valid,
   output logic [ADDR_W-1:0] lbp_addr,
   output logic              finish
);
   import lbp_pkg::*;

   localparam int unsigned     RC_W     = $clog2(IMG_W);
   localparam logic [RC_W-1:0] RC_FIRST = RC_W'(1);
   localparam logic [RC_W-1:0] RC_LAST  = RC_W'(IMG_W - 2);

   state_e            state_q, state_d;
   logic [RC_W-1:0]   r_q, r_d;
   logic [RC_W-1:0]   c_q, c_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        slot;
   logic              fetching;
   logic [ADDR_W-1:0] gray_addr_raw;
   logic [ADDR_W-1:0] lbp_addr_raw;

   lbp_addr_gen #(
      .IMG_W  (IMG_W),
      .ADDR_W (ADDR_W),
      .RC_W   (RC_W)
   ) u_addr_gen (
      .r_i         (r_q),
      .c_i         (c_q),
      .slot_i      (slot),
      .gray_addr_o (gray_addr_raw),
      .lbp_addr_o  (lbp_addr_raw)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         r_q     <= RC_FIRST;
         c_q     <= RC_FIRST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      slot      = '0;
      fetching  = 1'b0;
      gray_req  = 1'b0;
      win_we    = 1'b0;
      win_shift = 1'b0;
      lbp_valid = 1'b0;
      finish    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gray_ready) begin
               state_d = FETCH9;
               r_d     = RC_FIRST;
               c_d     = RC_FIRST;
               cnt_d   = '0;
            end
         end
         FETCH9: begin
            fetching = 1'b1;
            slot     = cnt_q;
            if (gray_ready) begin
               gray_req = 1'b1;
               win_we   = 1'b1;
               if (cnt_q == 4'(SLOT_CNT - 1)) begin
                  cnt_d   = '0;
                  state_d = CALC;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         FETCH3: begin
            // Only the rightmost column (slots 2, 5, 8) is refilled after a shift.
            fetching = 1'b1;
            slot     = 4'd3 * cnt_q + 4'd2;
            if (gray_ready) begin
               gray_req = 1'b1;
               win_we   = 1'b1;
               if (cnt_q == 4'd2) begin
                  cnt_d   = '0;
                  state_d = CALC;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         CALC: begin
            lbp_valid = 1'b1;
            if (c_q < RC_LAST) begin
               win_shift = 1'b1;
               c_d       = c_q + RC_W'(1);
               state_d   = FETCH3;
            end else if (r_q < RC_LAST) begin
               c_d     = RC_FIRST;
               r_d     = r_q + RC_W'(1);
               state_d = FETCH9;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            finish = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign gray_addr = fetching ? gray_addr_raw : '0;
   assign win_idx   = slot;
   assign lbp_addr  = lbp_valid ? lbp_addr_raw : '0;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Self-checking bench for lbp_scan_ctrl: scan-order model built from the
// row/column rules, plus a window datapath model checked against direct LBP.
module tb_lbp_scan_ctrl;

   localparam int unsigned W    = 128;
   localparam int unsigned AW   = 14;
   localparam int unsigned NPIX = W * W;

   logic          clk = 1'b0;
   logic          reset;
   logic          gray_ready;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic          win_we;
   logic [3:0]    win_idx;
   logic          win_shift;
   logic          lbp_valid;
   logic [AW-1:0] lbp_addr;
   logic          finish;

   always #5 clk = ~clk;

   lbp_scan_ctrl #(
      .IMG_W  (W),
      .ADDR_W (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .gray_ready (gray_ready),
      .gray_req   (gray_req),
      .gray_addr  (gray_addr),
      .win_we     (win_we),
      .win_idx    (win_idx),
      .win_shift  (win_shift),
      .lbp_valid  (lbp_valid),
      .lbp_addr   (lbp_addr),
      .finish     (finish)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   typedef logic [7:0] pix9_t [9];
   typedef struct { int unsigned addr; int unsigned idx; } rd_t;
   typedef struct { int unsigned addr; bit shift; } wr_t;

   logic [7:0]  img [NPIX];
   pix9_t       win;
   rd_t         rd_q [$];
   wr_t         wr_q [$];
   bit          mon_en = 1'b0;
   bit          started;
   bit          exp_finish;
   bit          hit5000;
   int unsigned frame_cyc;
   int unsigned last_cyc;
   int unsigned n_writes;
   int unsigned reads_seen;

   // Neighbours in slot order (centre skipped) compared against the centre.
   function automatic int unsigned lbp_of(input pix9_t p);
      int unsigned code = 0;
      int unsigned k = 0;
      for (int unsigned i = 0; i < 9; i++) begin
         if (i != 4) begin
            if (p[i] >= p[4]) code |= 32'd1 << k;
            k++;
         end
      end
      return code;
   endfunction

   function automatic int unsigned golden(input int unsigned a);
      pix9_t p;
      int unsigned r = a / W;
      int unsigned c = a % W;
      for (int unsigned dr = 0; dr < 3; dr++)
         for (int unsigned dc = 0; dc < 3; dc++)
            p[3*dr+dc] = img[(r + dr - 1) * W + c + dc - 1];
      return lbp_of(p);
   endfunction

   task automatic new_frame();
      rd_t e;
      wr_t w;
      for (int unsigned i = 0; i < NPIX; i++) img[i] = 8'($urandom);
      rd_q.delete();
      wr_q.delete();
      for (int unsigned r = 1; r <= W - 2; r++) begin
         for (int unsigned c = 1; c <= W - 2; c++) begin
            if (c == 1) begin
               for (int unsigned dr = 0; dr < 3; dr++)
                  for (int unsigned dc = 0; dc < 3; dc++) begin
                     e.addr = (r - 1 + dr) * W + (c - 1 + dc);
                     e.idx  = 3 * dr + dc;
                     rd_q.push_back(e);
                  end
            end else begin
               for (int unsigned dr = 0; dr < 3; dr++) begin
                  e.addr = (r - 1 + dr) * W + c + 1;
                  e.idx  = 3 * dr + 2;
                  rd_q.push_back(e);
               end
            end
            w.addr  = r * W + c;
            w.shift = (c < W - 2);
            wr_q.push_back(w);
         end
      end
      started    = 1'b0;
      exp_finish = 1'b0;
      hit5000    = 1'b0;
      frame_cyc  = 0;
      last_cyc   = 0;
      n_writes   = 0;
      reads_seen = 0;
   endtask

   task automatic monitor();
      rd_t         e;
      wr_t         w;
      int unsigned r;
      int unsigned c;
      if (started) frame_cyc++;
      check_eq("finish", 32'(finish), 32'(exp_finish));
      if (!gray_ready) begin
         check_eq("stall_req", 32'(gray_req), 0);
         check_eq("stall_we", 32'(win_we), 0);
      end
      if (!lbp_valid) check_eq("stray_shift", 32'(win_shift), 0);
      if (gray_req || win_we) begin
         if (!started) begin
            started   = 1'b1;
            frame_cyc = 1;
         end
         if (rd_q.size() == 0) begin
            check_eq("rd_extra", 1, 0);
         end else begin
            e = rd_q.pop_front();
            reads_seen++;
            check_eq("gray_req", 32'(gray_req), 1);
            check_eq("win_we", 32'(win_we), 1);
            check_eq("gray_addr", 32'(gray_addr), e.addr);
            check_eq("win_idx", 32'(win_idx), e.idx);
            if (win_idx < 9) win[win_idx] = img[gray_addr];
         end
      end
      if (lbp_valid) begin
         check_eq("calc_req", 32'(gray_req), 0);
         if (wr_q.size() == 0) begin
            check_eq("wr_extra", 1, 0);
         end else begin
            w = wr_q.pop_front();
            check_eq("lbp_addr", 32'(lbp_addr), w.addr);
            check_eq("win_shift", 32'(win_shift), 32'(w.shift));
            check_eq("lbp_data", lbp_of(win), golden(w.addr));
            r = 32'(lbp_addr) / W;
            c = 32'(lbp_addr) % W;
            check_eq("interior", 32'(r >= 1 && r <= W - 2 && c >= 1 && c <= W - 2), 1);
            if (lbp_addr == AW'(5000)) hit5000 = 1'b1;
            n_writes++;
            last_cyc = frame_cyc;
            if (wr_q.size() == 0) exp_finish = 1'b1;
         end
         if (win_shift) begin
            for (int unsigned dr = 0; dr < 3; dr++) begin
               win[3*dr]   = win[3*dr+1];
               win[3*dr+1] = win[3*dr+2];
            end
         end
      end
   endtask

   task automatic tick(input logic rst, input logic rdy);
      @(posedge clk);
      #1;
      reset      = rst;
      gray_ready = rdy;
      @(negedge clk);
      if (mon_en) monitor();
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, ".gray_req"}, 32'(gray_req), 0);
      check_eq({tag, ".gray_addr"}, 32'(gray_addr), 0);
      check_eq({tag, ".win_we"}, 32'(win_we), 0);
      check_eq({tag, ".win_idx"}, 32'(win_idx), 0);
      check_eq({tag, ".win_shift"}, 32'(win_shift), 0);
      check_eq({tag, ".lbp_valid"}, 32'(lbp_valid), 0);
      check_eq({tag, ".lbp_addr"}, 32'(lbp_addr), 0);
      check_eq({tag, ".finish"}, 32'(finish), 0);
   endtask

   int unsigned forced;
   bit          forced_done;
   bit          in_forced;
   logic        rdy;

   initial begin
      reset      = 1'b1;
      gray_ready = 1'b0;
      repeat (3) tick(1'b1, 1'b0);
      check_quiet("reset");
      repeat (2) tick(1'b0, 1'b0);
      check_quiet("idle");

      // Frame A: random stalls, forced 5-cycle stall at first-window slot 4,
      // then reset when lbp_addr 5000 is written.
      new_frame();
      mon_en = 1'b1;
      tick(1'b0, 1'b1);
      check_eq("req_lat0", 32'(gray_req), 0);
      tick(1'b0, 1'b1);
      check_eq("req_lat1", 32'(gray_req), 1);
      forced      = 0;
      forced_done = 1'b0;
      for (int unsigned i = 0; i < 30000 && !hit5000; i++) begin
         in_forced = (forced > 0);
         if (in_forced) begin
            rdy = 1'b0;
            forced--;
         end else begin
            rdy = ($urandom_range(0, 19) != 0);
         end
         tick(1'b0, rdy);
         if (in_forced) check_eq("stall_addr", 32'(gray_addr), 129);
         if (!forced_done && reads_seen == 4) begin
            forced      = 5;
            forced_done = 1'b1;
         end
      end
      check_eq("reach_5000", 32'(hit5000), 1);

      mon_en = 1'b0;
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      check_quiet("mid_reset");
      tick(1'b1, 1'b1);
      check_quiet("reset_prio");
      tick(1'b0, 1'b0);
      check_quiet("post_reset");

      // Frame B: no stalls, full frame with timing.
      new_frame();
      mon_en = 1'b1;
      tick(1'b0, 1'b1);
      check_eq("b_req_lat0", 32'(gray_req), 0);
      for (int unsigned i = 0; i < 70000 && !exp_finish; i++) tick(1'b0, 1'b1);
      check_eq("frame_done", 32'(exp_finish), 1);
      check_eq("n_writes", n_writes, (W - 2) * (W - 2));
      check_eq("last_cycle", last_cyc, 64260);
      check_eq("reads_left", rd_q.size(), 0);
      repeat (6) tick(1'b0, 1'b1);
      check_eq("finish_hold", 32'(finish), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
